hazard_forward_ctrl: RTL and testbench

//  Hazard/forwarding controller for the 4-stage (ID/EX/MEM/WB) vector-ALU pipeline.

---
 rtl/hazard_forward_ctrl_if.sv | 56 +++++
 rtl/hazard_forward_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_ctrl_if.sv
// Signal bundle between the vector-ALU pipeline and its hazard/forwarding controller.
// The perf counter wires exist only when HAZ_PERF_EN is defined.
interface hazard_forward_ctrl_if #(
  parameter int OP_SIZE = 24,
  parameter int REG_W   = 4
);
  logic               id_valid;
  logic [REG_W-1:0]   id_rs1;
  logic [REG_W-1:0]   id_rs2;
  logic [REG_W-1:0]   id_rs3;
  logic               id_use1;
  logic               id_use2;
  logic               id_use3;
  logic [REG_W-1:0]   id_rd;
  logic               id_we;
  logic               id_is_load;
  logic               branch_taken;
  logic               mem_ready;
  logic [OP_SIZE-1:0] mem_result;
  logic [OP_SIZE-1:0] wb_result;

  logic               fa;
  logic               fb;
  logic               fc;
  logic [OP_SIZE-1:0] forward1;
  logic [OP_SIZE-1:0] forward2;
  logic [OP_SIZE-1:0] forward3;
  logic               stall_id;
  logic               bubble_ex;
  logic               stall_all;
  logic               flush_id;
`ifdef HAZ_PERF_EN
  logic [31:0]        perf_stall_cnt;
  logic [31:0]        perf_fwd_cnt;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs3, id_use1, id_use2, id_use3,
    output id_rd, id_we, id_is_load, branch_taken, mem_ready, mem_result, wb_result,
    input  fa, fb, fc, forward1, forward2, forward3,
    input  stall_id, bubble_ex, stall_all, flush_id
`ifdef HAZ_PERF_EN
    , input perf_stall_cnt, perf_fwd_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs3, id_use1, id_use2, id_use3,
    input  id_rd, id_we, id_is_load, branch_taken, mem_ready, mem_result, wb_result,
    output fa, fb, fc, forward1, forward2, forward3,
    output stall_id, bubble_ex, stall_all, flush_id
`ifdef HAZ_PERF_EN
    , output perf_stall_cnt, perf_fwd_cnt
`endif
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the ID/EX/MEM/WB vector-ALU pipeline.
// Define HAZ_PERF_EN to add saturating stall/forward performance counters.
module hazard_forward_ctrl #(
  parameter int OP_SIZE = 24,
  parameter int REG_W   = 4
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t                 state;
  state_t                 state_nxt;

  // Only EX and MEM producers are tracked: a result already in WB reaches
  // the regfile write-through, so it never needs forwarding at decode.
  logic [REG_W-1:0]       ex_rd;
  logic [REG_W-1:0]       mem_rd;
  logic                   ex_we;
  logic                   ex_ld;
  logic                   mem_we;
  logic                   mem_ld;

  logic [2:0]             f_q;
  logic [2:0]             src_q;

  logic [2:0][REG_W-1:0]  rs;
  logic [2:0]             used;
  logic [2:0]             hit_ex;
  logic [2:0]             hit_mem;
  logic                   mem_stall;
  logic                   advance;
  logic                   lu_hit;
  logic                   flush;
  logic                   load_use;
  logic                   kill_ex;

  assign rs   = {bus.id_rs3, bus.id_rs2, bus.id_rs1};
  assign used = {bus.id_use3, bus.id_use2, bus.id_use1} & {3{bus.id_valid}};

  always_comb begin
    hit_ex  = '0;
    hit_mem = '0;
    for (int i = 0; i < 3; i++) begin
      hit_ex[i]  = used[i] & ex_we  & (ex_rd  == rs[i]);
      hit_mem[i] = used[i] & mem_we & (mem_rd == rs[i]);
    end
  end

  assign mem_stall = mem_ld & ~bus.mem_ready;
  assign advance   = ~mem_stall;
  assign lu_hit    = ex_ld & (|hit_ex);

  // Priority: slow memory freezes everything, then branch flush, then load-use.
  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    load_use  = 1'b0;
    if (mem_stall) begin
      state_nxt = MEM_WAIT;
    end else if (bus.branch_taken) begin
      flush     = 1'b1;
      state_nxt = RUN;
    end else if (lu_hit) begin
      load_use  = 1'b1;
      state_nxt = LU_STALL;
    end else begin
      state_nxt = RUN;
    end
  end

  assign kill_ex       = flush | load_use;
  assign bus.stall_all = mem_stall;
  assign bus.stall_id  = load_use;
  assign bus.bubble_ex = kill_ex;
  assign bus.flush_id  = flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Shadow pipe and EX forward selects move together, only on advancing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rd  <= '0;
      ex_we  <= 1'b0;
      ex_ld  <= 1'b0;
      mem_rd <= '0;
      mem_we <= 1'b0;
      mem_ld <= 1'b0;
      f_q    <= '0;
      src_q  <= '0;
    end else if (advance) begin
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      mem_ld <= ex_ld;
      if (kill_ex) begin
        ex_rd <= '0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
        f_q   <= '0;
        src_q <= '0;
      end else begin
        ex_rd <= bus.id_rd;
        ex_we <= bus.id_valid & bus.id_we & (|bus.id_rd);
        ex_ld <= bus.id_valid & bus.id_is_load;
        f_q   <= hit_ex | hit_mem;
        src_q <= ~hit_ex & hit_mem;
      end
    end
  end

  assign bus.fa       = f_q[0];
  assign bus.fb       = f_q[1];
  assign bus.fc       = f_q[2];
  assign bus.forward1 = src_q[0] ? bus.wb_result : bus.mem_result;
  assign bus.forward2 = src_q[1] ? bus.wb_result : bus.mem_result;
  assign bus.forward3 = src_q[2] ? bus.wb_result : bus.mem_result;

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if ((load_use | mem_stall) && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (advance && (|f_q) && (fwd_cnt != 32'hFFFF_FFFF)) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cnt = stall_cnt;
  assign bus.perf_fwd_cnt   = fwd_cnt;
`endif
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed plus randomized bench for hazard_forward_ctrl against an instruction-level
// model of the pipeline; perf counters are checked too when HAZ_PERF_EN is defined.
module tb_hazard_forward_ctrl;
  localparam int OP_SIZE = 24;
  localparam int REG_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.OP_SIZE(OP_SIZE), .REG_W(REG_W)) bus ();

  hazard_forward_ctrl #(.OP_SIZE(OP_SIZE), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
  logic             m_we  [3];
  logic [REG_W-1:0] m_rd  [3];
  logic             m_ld  [3];
  logic             m_f   [3];
  logic             m_src [3];
  logic             last_hold;
`ifdef HAZ_PERF_EN
  logic [31:0]      m_pstall;
  logic [31:0]      m_pfwd;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      m_we[k]  = 1'b0;
      m_rd[k]  = '0;
      m_ld[k]  = 1'b0;
      m_f[k]   = 1'b0;
      m_src[k] = 1'b0;
    end
    last_hold = 1'b0;
`ifdef HAZ_PERF_EN
    m_pstall = '0;
    m_pfwd   = '0;
`endif
  endtask

  // Youngest in-flight stage that will write register s, or -1.
  function automatic int producer(input logic [REG_W-1:0] s);
    for (int k = 0; k < 3; k++) begin
      if (s != '0 && m_we[k] && m_rd[k] == s) return k;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic v, input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2,
                               input logic [REG_W-1:0] r3, input logic [2:0] u, input logic [REG_W-1:0] rd,
                               input logic we, input logic ld, input logic br, input logic mr,
                               input logic [OP_SIZE-1:0] mres, input logic [OP_SIZE-1:0] wres);
    @(negedge clk);
    bus.id_valid     = v;
    bus.id_rs1       = r1;
    bus.id_rs2       = r2;
    bus.id_rs3       = r3;
    bus.id_use1      = u[0];
    bus.id_use2      = u[1];
    bus.id_use3      = u[2];
    bus.id_rd        = rd;
    bus.id_we        = we;
    bus.id_is_load   = ld;
    bus.branch_taken = br;
    bus.mem_ready    = mr;
    bus.mem_result   = mres;
    bus.wb_result    = wres;
    #1;
  endtask

  task automatic verifyCycle(input string tag);
    logic [REG_W-1:0] srcs [3];
    logic [2:0]       used;
    int               p [3];
    logic             e_sa, adv, e_fl, hit_lu, e_lu, kill, any_f;
    srcs[0] = bus.id_rs1;
    srcs[1] = bus.id_rs2;
    srcs[2] = bus.id_rs3;
    used    = {bus.id_use3, bus.id_use2, bus.id_use1} & {3{bus.id_valid}};
    e_sa    = m_ld[1] & ~bus.mem_ready;
    adv     = ~e_sa;
    e_fl    = adv & bus.branch_taken;
    hit_lu  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p[i] = used[i] ? producer(srcs[i]) : -1;
      if (p[i] == 0 && m_ld[0]) hit_lu = 1'b1;
    end
    e_lu  = adv & ~e_fl & hit_lu;
    kill  = e_lu | e_fl;
    any_f = m_f[0] | m_f[1] | m_f[2];

    checkOutput({tag, ".stall_all"}, 32'(bus.stall_all), 32'(e_sa));
    checkOutput({tag, ".stall_id"},  32'(bus.stall_id),  32'(e_lu));
    checkOutput({tag, ".bubble_ex"}, 32'(bus.bubble_ex), 32'(kill));
    checkOutput({tag, ".flush_id"},  32'(bus.flush_id),  32'(e_fl));
    checkOutput({tag, ".fa"}, 32'(bus.fa), 32'(m_f[0]));
    checkOutput({tag, ".fb"}, 32'(bus.fb), 32'(m_f[1]));
    checkOutput({tag, ".fc"}, 32'(bus.fc), 32'(m_f[2]));
    checkOutput({tag, ".forward1"}, 32'(bus.forward1), 32'(m_src[0] ? bus.wb_result : bus.mem_result));
    checkOutput({tag, ".forward2"}, 32'(bus.forward2), 32'(m_src[1] ? bus.wb_result : bus.mem_result));
    checkOutput({tag, ".forward3"}, 32'(bus.forward3), 32'(m_src[2] ? bus.wb_result : bus.mem_result));
`ifdef HAZ_PERF_EN
    checkOutput({tag, ".perf_stall"}, bus.perf_stall_cnt, m_pstall);
    checkOutput({tag, ".perf_fwd"},   bus.perf_fwd_cnt,   m_pfwd);
    if ((e_lu | e_sa) && m_pstall != 32'hFFFF_FFFF) m_pstall = m_pstall + 32'd1;
    if (adv && any_f && m_pfwd != 32'hFFFF_FFFF) m_pfwd = m_pfwd + 32'd1;
`endif

    if (adv) begin
      for (int k = 2; k > 0; k--) begin
        m_we[k] = m_we[k-1];
        m_rd[k] = m_rd[k-1];
        m_ld[k] = m_ld[k-1];
      end
      m_we[0] = ~kill & bus.id_valid & bus.id_we;
      m_rd[0] = kill ? '0 : bus.id_rd;
      m_ld[0] = ~kill & bus.id_valid & bus.id_is_load;
      for (int i = 0; i < 3; i++) begin
        m_f[i]   = ~kill & (p[i] == 0 || p[i] == 1);
        m_src[i] = ~kill & (p[i] == 1);
      end
    end
    last_hold = e_lu | e_sa;
    if (any_f === 1'bx) $display("[TB] model select went unknown at %s", tag);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".fa"},        32'(bus.fa),        32'd0);
    checkOutput({tag, ".fb"},        32'(bus.fb),        32'd0);
    checkOutput({tag, ".fc"},        32'(bus.fc),        32'd0);
    checkOutput({tag, ".stall_id"},  32'(bus.stall_id),  32'd0);
    checkOutput({tag, ".bubble_ex"}, 32'(bus.bubble_ex), 32'd0);
    checkOutput({tag, ".stall_all"}, 32'(bus.stall_all), 32'd0);
    checkOutput({tag, ".flush_id"},  32'(bus.flush_id),  32'd0);
    checkOutput({tag, ".forward1"},  32'(bus.forward1),  32'd0);
  endtask

  initial begin
    logic             rv, rwe, rld;
    logic [REG_W-1:0] r1, r2, r3, rrd;
    logic [2:0]       ru;
    rv = 1'b0; rwe = 1'b0; rld = 1'b0;
    r1 = '0; r2 = '0; r3 = '0; rrd = '0; ru = '0;

    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs3 = '0;
    bus.id_use1 = 1'b0; bus.id_use2 = 1'b0; bus.id_use3 = 1'b0;
    bus.id_rd = '0; bus.id_we = 1'b0; bus.id_is_load = 1'b0;
    bus.branch_taken = 1'b0; bus.mem_ready = 1'b1;
    bus.mem_result = '0; bus.wb_result = '0;
    modelReset();
    #2;
    checkZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // ADD r3 ; SUB r5,r3,r2 -> forward op1 from MEM
    applyStimulus(1, 1, 2, 0, 3'b011, 3, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t1.add");
    applyStimulus(1, 3, 2, 0, 3'b011, 5, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t1.sub");
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 24'h00ABCD, 24'($urandom));
    verifyCycle("t1.ex");
    checkOutput("t1.fa_const", 32'(bus.fa), 32'd1);
    checkOutput("t1.fb_const", 32'(bus.fb), 32'd0);
    checkOutput("t1.fwd1_const", 32'(bus.forward1), 32'h00ABCD);

    // ADD r4 ; NOP ; MUL r6,r1,r4 -> forward op2 from WB
    applyStimulus(1, 1, 2, 0, 3'b011, 4, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t2.add");
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t2.nop");
    applyStimulus(1, 1, 4, 0, 3'b011, 6, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t2.mul");
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 24'($urandom), 24'h123456);
    verifyCycle("t2.ex");
    checkOutput("t2.fa_const", 32'(bus.fa), 32'd0);
    checkOutput("t2.fb_const", 32'(bus.fb), 32'd1);
    checkOutput("t2.fwd2_const", 32'(bus.forward2), 32'h123456);

    // LOAD r7 ; ADD r8,r7,r7 -> one bubble, then both operands from WB
    applyStimulus(1, 1, 0, 0, 3'b001, 7, 1, 1, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t3.load");
    applyStimulus(1, 7, 7, 0, 3'b011, 8, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t3.lu");
    checkOutput("t3.stall_id_const", 32'(bus.stall_id), 32'd1);
    checkOutput("t3.bubble_const", 32'(bus.bubble_ex), 32'd1);
    applyStimulus(1, 7, 7, 0, 3'b011, 8, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t3.redecode");
    checkOutput("t3.stall_id_clear", 32'(bus.stall_id), 32'd0);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 24'($urandom), 24'h0F0F0F);
    verifyCycle("t3.ex");
    checkOutput("t3.fa_const", 32'(bus.fa), 32'd1);
    checkOutput("t3.fb_const", 32'(bus.fb), 32'd1);
    checkOutput("t3.fwd2_const", 32'(bus.forward2), 32'h0F0F0F);

    // LOAD r9 stuck in MEM for three cycles
    applyStimulus(1, 1, 0, 0, 3'b001, 9, 1, 1, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t4.load");
    applyStimulus(1, 3, 2, 0, 3'b011, 10, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t4.add");
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1, 10, 1, 0, 3'b011, 11, 1, 0, 0, 0, 24'($urandom), 24'($urandom));
      verifyCycle("t4.wait");
      checkOutput("t4.stall_all_const", 32'(bus.stall_all), 32'd1);
    end
    applyStimulus(1, 10, 1, 0, 3'b011, 11, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t4.release");
    checkOutput("t4.released", 32'(bus.stall_all), 32'd0);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 24'h0000AA, 24'($urandom));
    verifyCycle("t4.ex");
    checkOutput("t4.fa_const", 32'(bus.fa), 32'd1);
    checkOutput("t4.fwd1_const", 32'(bus.forward1), 32'h0000AA);

    // branch over a load-use, then r0 writes never forward
    applyStimulus(1, 1, 0, 0, 3'b001, 12, 1, 1, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t5.load");
    applyStimulus(1, 12, 0, 0, 3'b001, 13, 1, 0, 1, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t5.branch");
    checkOutput("t5.flush_const", 32'(bus.flush_id), 32'd1);
    checkOutput("t5.bubble_const", 32'(bus.bubble_ex), 32'd1);
    checkOutput("t5.stall_id_const", 32'(bus.stall_id), 32'd0);
    applyStimulus(1, 1, 2, 0, 3'b011, 0, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t5.wr_r0");
    applyStimulus(1, 0, 0, 0, 3'b011, 14, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t5.rd_r0");
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t5.ex");
    checkOutput("t5.fa_const", 32'(bus.fa), 32'd0);
    checkOutput("t5.fb_const", 32'(bus.fb), 32'd0);

    // reset asserted while waiting on memory
    applyStimulus(1, 1, 0, 0, 3'b001, 15, 1, 1, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t6.load");
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t6.nop");
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 24'($urandom), 24'($urandom));
    verifyCycle("t6.wait");
    checkOutput("t6.stall_all_const", 32'(bus.stall_all), 32'd1);
    #1;
    rst = 1'b1;
    bus.mem_result = '0;
    #1;
    checkZero("t6.rst");
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 24'($urandom), 24'($urandom));
    verifyCycle("t6.after");
    checkOutput("t6.no_stall", 32'(bus.stall_all), 32'd0);
    applyStimulus(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t6.add");
    applyStimulus(1, 2, 1, 0, 3'b011, 3, 1, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t6.sub");
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 24'($urandom), 24'($urandom));
    verifyCycle("t6.ex");
    checkOutput("t6.fa_const", 32'(bus.fa), 32'd1);

    // random instruction stream; a stalled instruction stays in ID
    for (int n = 0; n < 400; n++) begin
      if (!last_hold) begin
        rv  = ($urandom_range(7) != 0);
        r1  = REG_W'($urandom_range(5));
        r2  = REG_W'($urandom_range(5));
        r3  = REG_W'($urandom_range(5));
        ru  = 3'($urandom_range(7));
        rrd = REG_W'($urandom_range(5));
        rwe = ($urandom_range(3) != 0);
        rld = ($urandom_range(2) == 0);
      end
      applyStimulus(rv, r1, r2, r3, ru, rrd, rwe, rld, ($urandom_range(9) == 0),
                    ($urandom_range(3) != 0), 24'($urandom), 24'($urandom));
      verifyCycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
